fsm_moore_seq_detect: RTL

Parametrised Moore sequence detector, successor to the fixed two-bit "snail" detector.
- Serial bit stream in; pattern length, pattern value and overlap mode are set by parameters.
- Adds a sample qualifier, a synchronous clear and a saturating match counter.
- Used wherever a control path needs to flag a fixed serial signature: the smile pulse and the count go to status logic.

---
 rtl/fsm_seq_detect_pkg.sv | 61 ++++++
 rtl/fsm_seq_sat_counter.sv | 33 +++
 rtl/fsm_moore_seq_detect.sv | 92 +++++++++
 3 files changed

// File: rtl/fsm_seq_detect_pkg.sv
// Shared definitions for the parametrised Moore sequence detector.
//
// Contents:
//   stateWidth()     - bits needed to hold match progress 0..patternLen
//   S0               - "nothing matched" progress value
//   nextTable_t      - packed next-state table, indexed [progress][bit]
//   buildNextTable() - constant function that fills the table from the
//                      pattern, its length and the overlap mode
package fsm_seq_detect_pkg;

  localparam int MAX_LEN = 16;
  localparam int ENTRY_W = 5;
  localparam int S0      = 0;

  typedef logic [MAX_LEN:0][1:0][ENTRY_W-1:0] nextTable_t;

  function automatic int stateWidth(input int patternLen);
    return $clog2(patternLen + 1);
  endfunction

  // For every progress value k and incoming bit b, the new progress is the
  // longest suffix of (matched prefix . b) that is also a pattern prefix.
  // Without overlap, leaving the full-match state starts from an empty
  // history, so only the new bit counts. Entries above patternLen stay 0.
  function automatic nextTable_t buildNextTable(input logic [MAX_LEN-1:0] pattern,
                                                input int patternLen,
                                                input bit overlap);
    nextTable_t tbl;
    logic       hist [0:MAX_LEN];
    int         histLen;
    int         best;
    bit         same;
    tbl = '0;
    for (int i = 0; i <= MAX_LEN; i++) hist[i] = 1'b0;
    for (int k = 0; k <= patternLen; k++) begin
      for (int b = 0; b < 2; b++) begin
        if (k == patternLen && !overlap) begin
          hist[0] = b[0];
          histLen = 1;
        end else begin
          for (int i = 0; i < k; i++) hist[i] = pattern[patternLen-1-i];
          hist[k] = b[0];
          histLen = k + 1;
        end
        best = 0;
        for (int j = 1; j <= patternLen; j++) begin
          if (j <= histLen) begin
            same = 1'b1;
            for (int i = 0; i < j; i++) begin
              if (hist[histLen-j+i] != pattern[patternLen-1-i]) same = 1'b0;
            end
            if (same) best = j;
          end
        end
        tbl[k][b] = ENTRY_W'(best);
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/fsm_seq_sat_counter.sv
// Saturating event counter used for status reporting.
//
// Ports:
//   clk_in - clock, rising edge
//   rst_in - synchronous active-high reset (highest priority)
//   clr    - synchronous clear to zero
//   inc    - add one unless already saturated
//   count  - current count, sticks at all ones
//   sat    - high while count is all ones
module fsm_seq_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  // Saturation is a pure decode of the count so it tracks it with no lag.
  assign sat = &count;

  // Reset and clear both return to zero; increments stop at all ones.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_moore_seq_detect.sv
// Parametrised Moore serial-pattern detector with saturating match count.
//
// Ports:
//   clk_in          - clock, rising edge
//   rst_in          - synchronous active-high reset
//   sample_in       - qualifier; sequence_in is consumed only when high
//   sequence_in     - serial data bit, PATTERN MSB arrives first
//   clear_in        - synchronous restart of detection and count
//   smile_out       - high while the registered state is the full-match state
//   match_count_out - matches since reset/clear, saturating
//   count_sat_out   - high while the count is all ones
//   dbg_state_out   - copy of the progress register, only present when
//                     FSM_MOORE_SEQ_DETECT_DBG_STATE_EN is defined
module fsm_moore_seq_detect
  import fsm_seq_detect_pkg::*;
#(
  parameter int                     PATTERN_LEN = 2,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 2'b01,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     CNT_W       = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sample_in,
  input  logic             sequence_in,
  input  logic             clear_in,
  output logic             smile_out,
  output logic [CNT_W-1:0] match_count_out,
  output logic             count_sat_out
`ifdef FSM_MOORE_SEQ_DETECT_DBG_STATE_EN
  ,
  output logic [stateWidth(PATTERN_LEN)-1:0] dbg_state_out
`endif
);

  localparam int SW = stateWidth(PATTERN_LEN);
  typedef logic [SW-1:0] state_t;

  localparam state_t     S_IDLE     = state_t'(S0);
  localparam state_t     S_MATCH    = state_t'(PATTERN_LEN);
  localparam nextTable_t NEXT_TABLE = buildNextTable(MAX_LEN'(PATTERN), PATTERN_LEN, OVERLAP);

  if (PATTERN_LEN < 2 || PATTERN_LEN > MAX_LEN) begin : g_bad_len
    $error("fsm_moore_seq_detect: PATTERN_LEN must be in 2..16");
  end

  state_t             state_q;
  state_t             state_d;
  logic               stateValid;
  logic               matchInc;
  logic [ENTRY_W-1:0] tblIdx;

  // Next progress comes straight from the elaborated table; encodings above
  // the full-match value are treated as corrupt and steered back to idle.
  always_comb begin
    tblIdx     = ENTRY_W'(state_q);
    stateValid = (state_q <= S_MATCH);
    state_d    = state_t'(NEXT_TABLE[tblIdx][sequence_in]);
    if (!stateValid) state_d = S_IDLE;
    matchInc   = sample_in && stateValid && (state_d == S_MATCH) && !clear_in && !rst_in;
  end

  // Reset beats clear beats sampling; a corrupt state recovers even when
  // no bit is being accepted.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      state_q <= S_IDLE;
    end else if (!stateValid) begin
      state_q <= S_IDLE;
    end else if (sample_in) begin
      state_q <= state_d;
    end
  end

  assign smile_out = (state_q == S_MATCH);

`ifdef FSM_MOORE_SEQ_DETECT_DBG_STATE_EN
  assign dbg_state_out = state_q;
`endif

  fsm_seq_sat_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .clr   (clear_in),
    .inc   (matchInc),
    .count (match_count_out),
    .sat   (count_sat_out)
  );

endmodule
